baby_store_loader: RTL and testbench
====================================

Name: baby_store_loader

Overview:
- Writes a program image into the Baby's 32-line store.
- The Baby CPU reads the store (and writes only on STO); this block is the bulk-write end of that store interface.
- Takes a byte stream with a valid/ready handshake, assembles 32-bit lines and issues one-cycle store writes at ascending addresses.
- Holds the CPU in WAITING (cpu_hold) until the image is complete.

Parameters:
- WORD_BITS, 32, store line width; must be a multiple of 8.
- ADDR_BITS, 5, store address width.
- LINES, 32, store depth; must equal 2**ADDR_BITS.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load when idle.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle; transfer occurs when in_valid & in_ready.
- ram_addr  out  ADDR_BITS  store write address.
- ram_din  out  WORD_BITS  store write data.
- ram_we  out  1  store write strobe, one cycle per line.
- cpu_hold  out  1  high while a load is in progress; CPU must not start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last line has been written.

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - All outputs 0: ram_addr=0, ram_din=0, ram_we=0, in_ready=0, cpu_hold=0, busy=0, done=0.
  - Internal byte index, line counter and word register cleared.
- Stream format: 1 header byte N, then N lines of 4 bytes each, little-endian (first byte goes to bits [7:0]).
  - Line count = N[ADDR_BITS-1:0]; the value 0 means LINES (32); upper header bits ignored.
- States and transitions:
  - IDLE: in_ready=0. On start=1, go to HEADER; cpu_hold and busy go high the next cycle.
  - HEADER: in_ready=1. On transfer, latch remaining=count, clear addr and byte index, go to BYTES.
  - BYTES: in_ready=1. Each transfer writes word[8*idx +: 8]=in_data and increments idx. The transfer with idx=BYTES_PER_WORD-1 goes to WRITE.
  - WRITE: in_ready=0. ram_we=1 for exactly this cycle, with ram_addr=current line and ram_din=assembled word. Next cycle: addr+1, remaining-1, idx=0. If remaining was 1 go to DONE, else go to BYTES.
  - DONE: done=1 for one cycle, in_ready=0. cpu_hold and busy drop on exit to IDLE.
- Timing:
  - ram_we asserts the cycle after the 4th byte of a line is accepted.
  - ram_addr/ram_din are registered and stable for the whole ram_we cycle.
  - Peak throughput is 5 cycles per line; in_valid gaps stall without loss.
- in_ready is a decode of state: high in HEADER and BYTES only.
- ram_we never asserts outside WRITE, and asserts once per line.
- ram_addr is never written beyond line count-1; the increment from 31 wraps to 0 but is unused, because the load ends there.
- start is ignored while busy. start coinciding with the DONE cycle is also ignored.
- in_valid while in_ready=0: no transfer, byte not consumed.
- Reset mid-load: immediate abort.
  - The partial word is discarded and cpu_hold is released.
  - Lines already written stay in the store; no further writes.
- Bytes offered after the last line are not consumed; they belong to the next load.

Decomposition:
- Shared package (used with the CPU and store) holds:
  - WORD_BITS, ADDR_BITS, LINES;
  - BYTES_PER_WORD = WORD_BITS/8;
  - the loader state encoding IDLE/HEADER/BYTES/WRITE/DONE.
- No sub-module is needed: the FSM, byte assembler and counters are one module.
- The store itself is the existing store RAM, driven through an external write-port mux selected by cpu_hold.

Test Plan:
- Reset then start; stream 01, 78 56 34 12 → one ram_we with ram_addr=0, ram_din=0x12345678 one cycle after the 4th byte; done pulses 1 cycle later; cpu_hold drops.
- Header 00, 128 bytes where each line k is {k,k,k,k} → 32 writes at addr 0..31 with ram_din=0x0k0k0k0k; no write after addr 31; done once.
- Header 03 with in_valid toggled randomly → exactly 3 writes, addr 0,1,2, correct data, no byte loss or duplication; in_ready is low during each WRITE cycle.
- Header 0xE2 (upper bits set) → count=2; exactly 2 writes.
- resetn pulsed low after 2 bytes of line 1 in a 3-line load → ram_we stays 0 afterwards; all outputs are 0 during reset; a new start loads from addr 0 correctly.
- start pulsed during BYTES and during DONE → no restart; write sequence unchanged.

Source files
------------

// File: rtl/baby_store_loader_pkg.sv
// -----------------------------------------------------------------------------
// baby_store_loader_pkg
// Shared definitions for the Baby store and its bulk loader. The CPU, the
// store RAM and the loader all use this package.
//   WORD_BITS      : store line width (multiple of 8)
//   ADDR_BITS      : store address width
//   LINES          : store depth (2**ADDR_BITS)
//   BYTES_PER_WORD : stream bytes per store line
//   load_state_e   : loader FSM state encoding
// -----------------------------------------------------------------------------
package baby_store_loader_pkg;

  localparam int WORD_BITS      = 32;
  localparam int ADDR_BITS      = 5;
  localparam int LINES          = 32;
  localparam int BYTES_PER_WORD = WORD_BITS / 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_BYTES  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } load_state_e;

endpackage : baby_store_loader_pkg

// File: rtl/baby_store_loader.sv
// -----------------------------------------------------------------------------
// baby_store_loader
// Writes a program image into the Baby's store from a byte stream.
// Stream: one header byte N (line count = N[ADDR_BITS-1:0], 0 means LINES),
// then N lines of BYTES_PER_WORD bytes each, little-endian. Each completed
// line is written with a one-cycle ram_we at ascending addresses from 0.
// The CPU is held (cpu_hold) for the whole load.
//
// Ports:
//   clk       in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   start     in   one-cycle pulse, begins a load when idle
//   in_data   in   stream byte
//   in_valid  in   in_data valid
//   in_ready  out  byte accepted this cycle when in_valid & in_ready
//   ram_addr  out  store write address (registered)
//   ram_din   out  store write data (registered)
//   ram_we    out  store write strobe, one cycle per line
//   cpu_hold  out  load in progress, CPU must stay in WAITING
//   busy      out  FSM not idle
//   done      out  one-cycle pulse after the last line is written
// -----------------------------------------------------------------------------
module baby_store_loader
  import baby_store_loader_pkg::*;
#(
  parameter int WORD_BITS = baby_store_loader_pkg::WORD_BITS,
  parameter int ADDR_BITS = baby_store_loader_pkg::ADDR_BITS,
  parameter int LINES     = baby_store_loader_pkg::LINES
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [WORD_BITS-1:0] ram_din,
  output logic                 ram_we,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done
);

  localparam int BPW      = WORD_BITS / 8;
  localparam int IDX_BITS = (BPW > 1) ? $clog2(BPW) : 1;
  // One extra bit so a full-store load (LINES) is representable.
  localparam int CNT_BITS = ADDR_BITS + 1;

  load_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [CNT_BITS-1:0]  remain_q, remain_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic [WORD_BITS-1:0] word_q, word_d;

  logic                 ready_s;
  logic                 xfer_s;
  logic [CNT_BITS-1:0]  count_s;

  // Ready is a pure state decode, so a byte offered outside HEADER/BYTES waits.
  assign ready_s = (state_q == ST_HEADER) || (state_q == ST_BYTES);
  assign xfer_s  = in_valid && ready_s;

  // Header byte to line count; a zero count field selects the full store.
  always_comb begin
    count_s = {1'b0, in_data[ADDR_BITS-1:0]};
    if (in_data[ADDR_BITS-1:0] == {ADDR_BITS{1'b0}}) begin
      count_s = CNT_BITS'(LINES);
    end else begin
      count_s = {1'b0, in_data[ADDR_BITS-1:0]};
    end
  end

  // Next-state logic for the FSM, byte assembler and line counters.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    idx_d    = idx_q;
    word_d   = word_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HEADER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (xfer_s) begin
          remain_d = count_s;
          addr_d   = {ADDR_BITS{1'b0}};
          idx_d    = {IDX_BITS{1'b0}};
          state_d  = ST_BYTES;
        end else begin
          state_d  = ST_HEADER;
        end
      end
      ST_BYTES: begin
        if (xfer_s) begin
          word_d[8*idx_q +: 8] = in_data;
          if (idx_q == IDX_BITS'(BPW - 1)) begin
            idx_d   = {IDX_BITS{1'b0}};
            state_d = ST_WRITE;
          end else begin
            idx_d   = idx_q + IDX_BITS'(1);
            state_d = ST_BYTES;
          end
        end else begin
          state_d = ST_BYTES;
        end
      end
      ST_WRITE: begin
        // Address wraps from LINES-1 to 0 on the final line; it is unused then.
        addr_d   = addr_q + ADDR_BITS'(1);
        remain_d = remain_q - CNT_BITS'(1);
        idx_d    = {IDX_BITS{1'b0}};
        if (remain_q == CNT_BITS'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_BYTES;
        end
      end
      ST_DONE: begin
        // start in this cycle is deliberately dropped.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any load in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      addr_q   <= {ADDR_BITS{1'b0}};
      remain_q <= {CNT_BITS{1'b0}};
      idx_q    <= {IDX_BITS{1'b0}};
      word_q   <= {WORD_BITS{1'b0}};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
    end
  end

  // Outputs are registers or decodes of the state register only.
  assign in_ready = ready_s;
  assign ram_addr = addr_q;
  assign ram_din  = word_q;
  assign ram_we   = (state_q == ST_WRITE);
  assign done     = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);
  assign cpu_hold = (state_q != ST_IDLE);

endmodule : baby_store_loader

// File: tb/tb_baby_store_loader.sv
// -----------------------------------------------------------------------------
// tb_baby_store_loader
// Directed self-checking bench for baby_store_loader: per-cycle vector tables
// for short loads plus scripted sequences for full-store, stalled-stream and
// reset-abort loads.
// -----------------------------------------------------------------------------
module tb_baby_store_loader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  // flags = {in_ready, ram_we, cpu_hold, busy, done}
  localparam logic [4:0] F_IDLE = 5'b00000;
  localparam logic [4:0] F_RX   = 5'b10110;
  localparam logic [4:0] F_WR   = 5'b01110;
  localparam logic [4:0] F_DONE = 5'b00111;

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic [4:0]  flags;
    logic [4:0]  addr;
    logic [31:0] din;
  } vec_t;

  vec_t        tbl[$];
  logic [36:0] wq[$];
  int          done_cnt = 0;
  int          viol     = 0;

  baby_store_loader dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Write/done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (ram_we) wq.push_back({ram_addr, ram_din});
      if (ram_we && in_ready) viol++;
      if (done) done_cnt++;
    end
  end

  function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                              input logic [4:0] f, input logic [4:0] a,
                              input logic [31:0] w);
    vec_t r;
    r.start = s; r.valid = v; r.data = d; r.flags = f; r.addr = a; r.din = w;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      start    = tbl[i].start;
      in_valid = tbl[i].valid;
      in_data  = tbl[i].data;
      chk($sformatf("%s_flags_%0d", nm, i),
          64'({in_ready, ram_we, cpu_hold, busy, done}), 64'(tbl[i].flags));
      if (tbl[i].flags[3]) begin
        chk($sformatf("%s_write_%0d", nm, i), 64'({ram_addr, ram_din}),
            64'({tbl[i].addr, tbl[i].din}));
      end
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50; t++) begin
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int found = 0;
    for (int t = 0; t < 200 && found == 0; t++) begin
      if (done) found = 1;
      tick();
    end
    chk({nm, "_done_seen"}, 64'(found), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(nm, 64'({ram_addr, ram_din, in_ready, ram_we, cpu_hold, busy, done}), 64'd0);
  endtask

  initial begin
    logic [31:0] exp_w[3];
    logic [7:0]  b;
    int          base;
    int          dbase;

    resetn   = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    chk_reset_outputs("reset_outputs");
    resetn = 1'b1;
    tick();

    // One-line load; bytes offered during WRITE/DONE are not consumed.
    tbl.delete();
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, F_IDLE, 5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h01, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h78, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h56, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h34, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h12, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hAA, F_WR,   5'd0, 32'h12345678));
    tbl.push_back(mk(1'b0, 1'b1, 8'hAA, F_DONE, 5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, F_IDLE, 5'd0, 32'd0));
    run_table("one_line");

    // Header E2 -> 2 lines; valid gap, start during BYTES and during DONE.
    tbl.delete();
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, F_IDLE, 5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hE2, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h11, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b1, 1'b0, 8'hFF, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h22, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h33, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h44, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h55, F_WR,   5'd0, 32'h44332211));
    tbl.push_back(mk(1'b0, 1'b1, 8'h55, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h66, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h77, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h88, F_RX,   5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, F_WR,   5'd1, 32'h88776655));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, F_DONE, 5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h99, F_IDLE, 5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h99, F_IDLE, 5'd0, 32'd0));
    run_table("hdr_e2");
    chk("hdr_e2_write_count", 64'(wq.size()), 64'd3);

    // Full store: header 00, line k = {k,k,k,k}.
    wq.delete();
    dbase = done_cnt;
    pulse_start();
    send_byte(8'h00, 0);
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 4; j++) send_byte(8'(k), 0);
    end
    wait_done("full");
    repeat (5) tick();
    chk("full_write_count", 64'(wq.size()), 64'd32);
    for (int k = 0; k < 32 && k < wq.size(); k++) begin
      chk($sformatf("full_line_%0d", k), 64'(wq[k]),
          64'({5'(k), {4{8'(k)}}}));
    end
    chk("full_done_count", 64'(done_cnt - dbase), 64'd1);

    // Header 03 with random valid gaps.
    wq.delete();
    viol = 0;
    pulse_start();
    send_byte(8'h03, $urandom_range(0, 2));
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'($urandom_range(0, 255));
        exp_w[k][8*j +: 8] = b;
        send_byte(b, $urandom_range(0, 3));
      end
    end
    wait_done("gaps");
    chk("gaps_write_count", 64'(wq.size()), 64'd3);
    for (int k = 0; k < 3 && k < wq.size(); k++) begin
      chk($sformatf("gaps_line_%0d", k), 64'(wq[k]), 64'({5'(k), exp_w[k]}));
    end
    chk("ready_low_in_write", 64'(viol), 64'd0);

    // Reset after 2 bytes of line 1 in a 3-line load.
    wq.delete();
    pulse_start();
    send_byte(8'h03, 0);
    for (int j = 0; j < 6; j++) send_byte(8'hC0 + 8'(j), 0);
    resetn = 1'b0;
    #2;
    chk_reset_outputs("abort_reset_outputs");
    tick();
    chk_reset_outputs("abort_reset_outputs_held");
    resetn = 1'b1;
    base = wq.size();
    chk("abort_pre_writes", 64'(base), 64'd1);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (8) tick();
    chk("abort_ready_low", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    chk("abort_no_more_writes", 64'(wq.size()), 64'(base));
    wq.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    wait_done("reload");
    chk("reload_write_count", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) chk("reload_line_0", 64'(wq[0]), 64'({5'd0, 32'hDEADBEEF}));
    chk("reload_idle", 64'({cpu_hold, busy}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_baby_store_loader
